// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source 2-entry result FIFOs, round-robin pop, registered CDB/ROB broadcast.
// Define CDB_FIXED_PRIORITY_EN to replace round-robin with fixed priority (lowest source index wins).
module cdb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int ROB_W   = 4,
  parameter logic [TAG_W-1:0] NO_LOCK = '1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [1:0]                  cdb_src,
  output logic                        rob_write,
  output logic [ROB_W-1:0]            rob_entry,
  output logic [DATA_W-1:0]           rob_value
);

  logic [TAG_W-1:0]   tag_mem  [NUM_SRC][2];
  logic [DATA_W-1:0]  data_mem [NUM_SRC][2];
  logic [1:0]         count     [NUM_SRC];
  logic [1:0]         count_nxt [NUM_SRC];
  logic [NUM_SRC-1:0] rd_ptr;
  logic [NUM_SRC-1:0] wr_ptr;
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               grant_valid;
  logic [1:0]         grant_idx;
  logic [TAG_W-1:0]   grant_tag;
  logic [DATA_W-1:0]  grant_data;

  assign push = src_valid & src_ready;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      nonempty[i] = (count[i] != 2'd0);
    end
  end

`ifdef CDB_FIXED_PRIORITY_EN
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_valid && nonempty[i]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(i);
      end
    end
  end
`else
  localparam logic [1:0] LAST_RST = 2'(NUM_SRC - 1);

  logic [1:0] last;

  // Search starts just after the most recent grant so every source gets a turn.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!grant_valid && nonempty[i] && (((int'(last) + k) % NUM_SRC) == i)) begin
          grant_valid = 1'b1;
          grant_idx   = 2'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= LAST_RST;
    end else if (!flush && grant_valid) begin
      last <= grant_idx;
    end
  end
`endif

  always_comb begin
    grant_tag  = NO_LOCK;
    grant_data = '0;
    pop        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_valid && (grant_idx == 2'(i))) begin
        pop[i]     = 1'b1;
        grant_tag  = tag_mem[i][rd_ptr[i]];
        grant_data = data_mem[i][rd_ptr[i]];
      end
      count_nxt[i] = count[i] + {1'b0, push[i]} - {1'b0, pop[i]};
    end
  end

  // Ready is registered from the next count so it never depends on src_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i] <= 2'd0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      src_ready <= '1;
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i] <= 2'd0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      src_ready <= '1;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i]     <= count_nxt[i];
        src_ready[i] <= (count_nxt[i] < 2'd2);
        if (push[i]) begin
          wr_ptr[i] <= ~wr_ptr[i];
        end
        if (pop[i]) begin
          rd_ptr[i] <= ~rd_ptr[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i] && !flush) begin
        tag_mem[i][wr_ptr[i]]  <= src_tag[i*TAG_W +: TAG_W];
        data_mem[i][wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Results without a ROB destination are broadcast but leave the ROB port untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= NO_LOCK;
      cdb_data  <= '0;
      cdb_src   <= 2'd0;
      rob_write <= 1'b0;
      rob_entry <= '0;
      rob_value <= '0;
    end else if (flush || !grant_valid) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= NO_LOCK;
      cdb_data  <= '0;
      rob_write <= 1'b0;
    end else begin
      cdb_valid <= 1'b1;
      cdb_tag   <= grant_tag;
      cdb_data  <= grant_data;
      cdb_src   <= grant_idx;
      rob_write <= (grant_tag != NO_LOCK);
      if (grant_tag != NO_LOCK) begin
        rob_entry <= grant_tag[ROB_W-1:0];
        rob_value <= grant_data;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round-robin order, single push, NO_LOCK, backpressure, flush, reset mid-traffic.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_tag;
  logic [95:0] src_data;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
  logic        rob_write;
  logic [3:0]  rob_entry;
  logic [31:0] rob_value;

  int total;
  int bad;
  int n [3];
  logic [2:0] rdy;
  logic [2:0] vld;
  int exp_src;
  int exp_n;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .rob_write (rob_write),
    .rob_entry (rob_entry),
    .rob_value (rob_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] v,
                                input logic [4:0] t0, input logic [4:0] t1, input logic [4:0] t2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    src_valid = v;
    src_tag   = {t2, t1, t0};
    src_data  = {d2, d1, d0};
  endtask

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h, want %0h", name, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    flush = 1'b0;
    apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    #2 rst = 1'b0;
    tick();
    tick();
    check_output("rst_valid", 64'(cdb_valid), 64'd0);
    check_output("rst_tag",   64'(cdb_tag),   64'h1F);
    check_output("rst_data",  64'(cdb_data),  64'd0);
    check_output("rst_src",   64'(cdb_src),   64'd0);
    check_output("rst_robw",  64'(rob_write), 64'd0);
    check_output("rst_robe",  64'(rob_entry), 64'd0);
    check_output("rst_robv",  64'(rob_value), 64'd0);
    check_output("rst_ready", 64'(src_ready), 64'h7);
    rst = 1'b1;

    // Round-robin: two entries per source, tags 0..5 in expected order
    apply_stimulus(3'b111, 5'd0, 5'd1, 5'd2, 32'h100, 32'h101, 32'h102);
    tick();
    check_output("rr_first_idle", 64'(cdb_valid), 64'd0);
    apply_stimulus(3'b111, 5'd3, 5'd4, 5'd5, 32'h103, 32'h104, 32'h105);
    tick();
    apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    check_output("rr_ready_b", 64'(src_ready), 64'h1);
    for (int k = 0; k < 6; k++) begin
      check_output("rr_valid", 64'(cdb_valid), 64'd1);
      check_output("rr_src",   64'(cdb_src),   64'(k % 3));
      check_output("rr_tag",   64'(cdb_tag),   64'(k));
      check_output("rr_data",  64'(cdb_data),  64'(32'h100 + k));
      if (k == 1) check_output("rr_ready_c", 64'(src_ready), 64'h3);
      tick();
    end
    check_output("rr_idle_valid", 64'(cdb_valid), 64'd0);
    check_output("rr_idle_tag",   64'(cdb_tag),   64'h1F);
    check_output("rr_idle_data",  64'(cdb_data),  64'd0);

    // Single push from source 1
    apply_stimulus(3'b010, 5'd0, 5'd3, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0);
    tick();
    apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    check_output("sp_latency", 64'(cdb_valid), 64'd0);
    tick();
    check_output("sp_valid", 64'(cdb_valid), 64'd1);
    check_output("sp_src",   64'(cdb_src),   64'd1);
    check_output("sp_tag",   64'(cdb_tag),   64'd3);
    check_output("sp_robw",  64'(rob_write), 64'd1);
    check_output("sp_robe",  64'(rob_entry), 64'd3);
    check_output("sp_robv",  64'(rob_value), 64'hDEADBEEF);
    tick();
    check_output("sp_idle",      64'(cdb_valid), 64'd0);
    check_output("sp_idle_robw", 64'(rob_write), 64'd0);
    check_output("sp_hold_robe", 64'(rob_entry), 64'd3);

    // NO_LOCK tag is broadcast but not written to the ROB
    apply_stimulus(3'b100, 5'd0, 5'd0, 5'h1F, 32'd0, 32'd0, 32'h1);
    tick();
    apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check_output("nl_valid", 64'(cdb_valid), 64'd1);
    check_output("nl_data",  64'(cdb_data),  64'h1);
    check_output("nl_tag",   64'(cdb_tag),   64'h1F);
    check_output("nl_src",   64'(cdb_src),   64'd2);
    check_output("nl_robw",  64'(rob_write), 64'd0);
    check_output("nl_robe",  64'(rob_entry), 64'd3);
    check_output("nl_robv",  64'(rob_value), 64'hDEADBEEF);
    tick();
    check_output("nl_idle", 64'(cdb_valid), 64'd0);

    // Backpressure: all sources request continuously for 10 edges, then drain
    for (int i = 0; i < 3; i++) n[i] = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k <= 10)
        apply_stimulus(3'b111, 5'(n[0]), 5'(8 + n[1]), 5'(16 + n[2]),
                       32'hA000_0000 + 32'(n[0]), 32'hA000_0100 + 32'(n[1]), 32'hA000_0200 + 32'(n[2]));
      else
        apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      rdy = src_ready;
      vld = src_valid;
      tick();
      for (int i = 0; i < 3; i++) if (vld[i] && rdy[i]) n[i]++;
      if (k == 1) begin
        check_output("bp_first_idle", 64'(cdb_valid), 64'd0);
      end else begin
        exp_src = (k - 2) % 3;
        exp_n   = (k - 2) / 3;
        check_output("bp_valid", 64'(cdb_valid), 64'd1);
        check_output("bp_src",   64'(cdb_src),   64'(exp_src));
        check_output("bp_tag",   64'(cdb_tag),   64'(exp_src * 8 + exp_n));
        check_output("bp_data",  64'(cdb_data),  64'(32'hA000_0000 + 32'(exp_src * 256 + exp_n)));
      end
      if (k == 2) check_output("bp_ready_e2", 64'(src_ready), 64'h1);
      if (k == 3) check_output("bp_ready_e3", 64'(src_ready), 64'h2);
    end
    tick();
    check_output("bp_drained", 64'(cdb_valid), 64'd0);
    check_output("bp_ready_end", 64'(src_ready), 64'h7);
    check_output("bp_acc0", 64'(n[0]), 64'd5);
    check_output("bp_acc1", 64'(n[1]), 64'd5);
    check_output("bp_acc2", 64'(n[2]), 64'd4);

    // Flush with four buffered entries plus one concurrent push
    apply_stimulus(3'b111, 5'd20, 5'd21, 5'd22, 32'hF20, 32'hF21, 32'hF22);
    tick();
    apply_stimulus(3'b011, 5'd23, 5'd24, 5'd0, 32'hF23, 32'hF24, 32'd0);
    tick();
    check_output("fl_pre_tag",   64'(cdb_tag),   64'd22);
    check_output("fl_pre_src",   64'(cdb_src),   64'd2);
    check_output("fl_pre_ready", 64'(src_ready), 64'h4);
    apply_stimulus(3'b100, 5'd0, 5'd0, 5'd25, 32'd0, 32'd0, 32'hF25);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    check_output("fl_valid", 64'(cdb_valid), 64'd0);
    check_output("fl_tag",   64'(cdb_tag),   64'h1F);
    check_output("fl_robw",  64'(rob_write), 64'd0);
    check_output("fl_ready", 64'(src_ready), 64'h7);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output("fl_no_stale", 64'(cdb_valid), 64'd0);
    end

    // Asynchronous reset while traffic is in flight
    apply_stimulus(3'b111, 5'd6, 5'd7, 5'd8, 32'h206, 32'h207, 32'h208);
    tick();
    apply_stimulus(3'b111, 5'd9, 5'd10, 5'd11, 32'h209, 32'h20A, 32'h20B);
    tick();
    apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    check_output("rm_pre_valid", 64'(cdb_valid), 64'd1);
    check_output("rm_pre_tag",   64'(cdb_tag),   64'd6);
    #3 rst = 1'b0;
    #1;
    check_output("rm_valid", 64'(cdb_valid), 64'd0);
    check_output("rm_tag",   64'(cdb_tag),   64'h1F);
    check_output("rm_robw",  64'(rob_write), 64'd0);
    check_output("rm_ready", 64'(src_ready), 64'h7);
    rst = 1'b1;
    tick();
    check_output("rm_no_stale1", 64'(cdb_valid), 64'd0);
    tick();
    check_output("rm_no_stale2", 64'(cdb_valid), 64'd0);
    apply_stimulus(3'b101, 5'd12, 5'd0, 5'd13, 32'h20C, 32'd0, 32'h20D);
    tick();
    apply_stimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check_output("rm_prio_src", 64'(cdb_src), 64'd0);
    check_output("rm_prio_tag", 64'(cdb_tag), 64'd12);
    tick();
    check_output("rm_next_src", 64'(cdb_src), 64'd2);
    check_output("rm_next_tag", 64'(cdb_tag), 64'd13);
    tick();
    check_output("rm_end_idle", 64'(cdb_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got running, want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
